move_mailbox_ctrl: RTL and testbench
====================================

Name: move_mailbox_ctrl

Overview:
- Avalon-MM slave controller that sequences one hardware move-generation engine on behalf of the HPS software.
- Software writes a start command. The block pulses the engine, collects the 12-bit moves the engine streams back into an internal FIFO, and reports done/overflow/timeout status.
- Software drains moves through a pop-on-read register.
- Sits between the HPS lightweight bridge and the chess engine datapath.

Parameters:
- FIFO_DEPTH, 16, number of move entries buffered; power of two, 2..256.
- TIMEOUT_W, 24, width of the watchdog cycle counter and of the TIMEOUT register field.

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- address  in  14  Avalon word address
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational, zero wait states
- eng_start  out  1  one-cycle start pulse to the engine
- eng_abort  out  1  one-cycle abort pulse to the engine
- eng_move_valid  in  1  engine presents a move this cycle
- eng_move  in  12  {from_row[2:0], from_col[2:0], to_row[2:0], to_col[2:0]}
- eng_done  in  1  engine finished; single-cycle pulse

Interface: one clock, clk; reset is synchronous and active-high, named reset.

Behaviour:

Register map (word addresses; all other addresses read 0, writes to them are ignored):
- 0x000 CTRL
  - Write: bit0 = START, bit1 = ABORT, bit2 = CLR (flush FIFO, clear sticky flags).
  - Read: bit0 busy, bit1 done, bit2 overflow, bit3 timeout, bits[15:8] FIFO count, bits[31:16] 0.
- 0x001 MOVE_POP
  - Read returns {valid, 19'b0, move[11:0]}. If the FIFO is non-empty: valid=1 and the head entry is popped at that clock edge. If empty: returns 0, no pop.
- 0x002 MOVE_TOTAL: 16-bit count of moves accepted this run, zero-extended; read-only.
- 0x003 TIMEOUT: R/W, TIMEOUT_W bits. Reset value is all ones.

Bus rules:
- If write and read are asserted together, write wins and readdata is 0.
- readdata is 0 whenever read is low.

FSM (IDLE, LAUNCH, RUN, DONE):
- IDLE: START write goes to LAUNCH, clears done/timeout, clears MOVE_TOTAL and flushes the FIFO.
- LAUNCH: eng_start=1 for exactly this cycle, then RUN.
- RUN: busy=1.
  - eng_done goes to DONE.
  - ABORT write drives eng_abort=1 for one cycle and goes to IDLE with done=0.
- DONE: done=1, then returns to IDLE on the same cycle; done stays sticky until the next START or CLR.
- START while busy (LAUNCH/RUN) is ignored.
- ABORT in IDLE is ignored.

FIFO:
- Push on eng_move_valid in LAUNCH or RUN only; moves arriving in other states are dropped.
- Push while full: move dropped, overflow sticky set, MOVE_TOTAL still increments (saturates at 0xFFFF).
- Simultaneous push and pop while full: both succeed, count unchanged, no overflow.
- Simultaneous push and pop while empty: pop returns 0, push lands, count=1.
- Pointers wrap modulo FIFO_DEPTH.
- eng_move_valid together with eng_done in the same cycle: the move is pushed.

CLR:
- In any state, flushes the FIFO and clears overflow, timeout and done.
- Does not change the FSM state.

Reset:
- FSM to IDLE, FIFO empty, all flags 0, MOVE_TOTAL 0, TIMEOUT all ones.
- eng_start=0, eng_abort=0, readdata=0.
- Reset mid-run aborts silently; no eng_abort pulse is issued.

Optional Feature:
WATCHDOG_EN
- Defined:
  - A cycle counter clears on LAUNCH and increments each RUN cycle.
  - When it equals TIMEOUT: eng_abort pulses one cycle, timeout sticky sets, FSM goes to IDLE with done=0.
- Undefined:
  - No counter.
  - CTRL bit3 reads 0.
  - TIMEOUT register reads 0 and writes are ignored.
  - RUN exits only on eng_done or ABORT.

Test Plan:
- Reset, then read CTRL -> 0x00000000; read TIMEOUT -> 0x00FFFFFF when WATCHDOG_EN is defined, 0 otherwise.
- Write CTRL=1; engine pushes moves 0x0C8 and 0x1D1, then eng_done. Expected:
  - eng_start high exactly 1 cycle after the write.
  - CTRL reads 0x00000202.
  - MOVE_POP reads 0x800000C8, then 0x800001D1, then 0x00000000.
  - MOVE_TOTAL reads 2.
- FIFO_DEPTH=16, engine pushes 17 moves -> CTRL count=16, overflow=1, MOVE_TOTAL=17; the 17th move is absent from the pops.
- Write CTRL=1 during RUN -> no second eng_start. Write CTRL=2 -> eng_abort pulses 1 cycle; CTRL reads busy=0, done=0.
- WATCHDOG_EN defined, TIMEOUT=5, START, no eng_done -> eng_abort on the 5th RUN cycle; CTRL bit3=1 and bit0=0.
- FIFO full, then a cycle with both push and MOVE_POP read -> count stays 16, overflow stays 0. Then write CTRL=4 -> count=0 and all flags 0.

Source files
------------

// File: rtl/move_mailbox_ctrl.sv
// move_mailbox_ctrl: Avalon-MM slave that launches the move-generation engine,
// buffers the 12-bit moves it streams back in a FIFO, and reports status.
// The optional watchdog is enabled by defining the macro WATCHDOG_EN.
module move_mailbox_ctrl #(
   parameter int FIFO_DEPTH = 16,
   parameter int TIMEOUT_W  = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] address,
   input  logic        write,
   input  logic        read,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        eng_start,
   output logic        eng_abort,
   input  logic        eng_move_valid,
   input  logic [11:0] eng_move,
   input  logic        eng_done
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   localparam logic [13:0] ADDR_CTRL    = 14'h000;
   localparam logic [13:0] ADDR_POP     = 14'h001;
   localparam logic [13:0] ADDR_TOTAL   = 14'h002;
   localparam logic [13:0] ADDR_TIMEOUT = 14'h003;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic [11:0]   mem_q [FIFO_DEPTH];
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   total_q, total_d;

   logic        accept_start, set_done, set_timeout, wd_hit, timeout_flag;
   logic [31:0] timeout_rd;

   // Bus decode: a write always takes precedence over a simultaneous read.
   logic rd_en, ctrl_wr, start_cmd, abort_cmd, clr_cmd;
   assign rd_en     = read & ~write;
   assign ctrl_wr   = write & (address == ADDR_CTRL);
   assign start_cmd = ctrl_wr & writedata[0];
   assign abort_cmd = ctrl_wr & writedata[1];
   assign clr_cmd   = ctrl_wr & writedata[2];

   logic busy, fifo_empty, fifo_full, push, pop, push_ok, flush, clear_flags;
   assign busy        = (state_q == S_LAUNCH) || (state_q == S_RUN);
   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == FULL_CNT);
   assign push        = eng_move_valid & busy;
   assign pop         = rd_en & (address == ADDR_POP) & ~fifo_empty;
   assign flush       = clr_cmd | accept_start;
   // A push into a full FIFO only lands if a pop frees the head slot this cycle.
   assign push_ok     = push & (~fifo_full | pop) & ~flush;
   assign clear_flags = clr_cmd | accept_start;

   // FSM next state and engine strobes.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
      state_d      = state_q;
      eng_start    = 1'b0;
      eng_abort    = 1'b0;
      accept_start = 1'b0;
      set_done     = 1'b0;
      set_timeout  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start_cmd) begin
               accept_start = 1'b1;
               state_d      = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            eng_start = 1'b1;
            state_d   = S_RUN;
         end
         S_RUN: begin
            if (abort_cmd) begin
               eng_abort = 1'b1;
               state_d   = S_IDLE;
            end else if (eng_done) begin
               set_done = 1'b1;
               state_d  = S_DONE;
            end else if (wd_hit) begin
               eng_abort   = 1'b1;
               set_timeout = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Reset kills a run silently: no strobes leave the block while it is held.
      if (reset) begin
         eng_start = 1'b0;
         eng_abort = 1'b0;
      end
   end

   // Sticky flags and move total next-state.
   always_comb begin
      done_d  = clear_flags ? 1'b0 : done_q;
      if (set_done) done_d = 1'b1;
      ovf_d   = clr_cmd ? 1'b0 : ovf_q;
      if (push && fifo_full && !pop && !flush) ovf_d = 1'b1;
      total_d = total_q;
      if (accept_start)                     total_d = '0;
      else if (push && total_q != 16'hFFFF) total_d = total_q + 16'd1;
   end

   // Control state, FIFO pointers and status registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         total_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         total_q <= total_d;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
         end
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is not reset; count_q alone decides which entries are valid.
      if (push_ok) mem_q[wr_ptr_q] <= eng_move;
   end

`ifdef WATCHDOG_EN
   logic [TIMEOUT_W-1:0] timeout_q, wd_cnt_q;
   logic                 timeout_flag_q;

   // The k-th RUN cycle sees wd_cnt_q == k-1, so the abort fires on RUN cycle TIMEOUT.
   assign wd_hit       = (state_q == S_RUN) && ((wd_cnt_q + TIMEOUT_W'(1)) == timeout_q);
   assign timeout_flag = timeout_flag_q;
   assign timeout_rd   = 32'(timeout_q);

   // Watchdog limit register, RUN cycle counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_q      <= '1;
         wd_cnt_q       <= '0;
         timeout_flag_q <= 1'b0;
      end else begin
         if (write && address == ADDR_TIMEOUT) timeout_q <= writedata[TIMEOUT_W-1:0];
         if (state_q == S_LAUNCH)   wd_cnt_q <= '0;
         else if (state_q == S_RUN) wd_cnt_q <= wd_cnt_q + TIMEOUT_W'(1);
         if (clear_flags) timeout_flag_q <= 1'b0;
         if (set_timeout) timeout_flag_q <= 1'b1;
      end
   end

   logic unused_bits;
   assign unused_bits = ^writedata[31:3];
`else
   assign wd_hit       = 1'b0;
   assign timeout_flag = 1'b0;
   assign timeout_rd   = '0;

   logic unused_bits;
   assign unused_bits = ^{writedata[31:3], set_timeout};
`endif

   // 8-bit count field; saturates so a full 256-deep FIFO still reads non-zero.
   logic [8:0] count_ext;
   logic [7:0] count_field;
   assign count_ext   = 9'(count_q);
   assign count_field = count_ext[8] ? 8'hFF : count_ext[7:0];

   // Zero-wait-state read mux; idle bus reads as zero.
   always_comb begin
      readdata = '0;
      if (rd_en && !reset) begin
         case (address)
            ADDR_CTRL:    readdata = {16'h0, count_field, 4'h0, timeout_flag, ovf_q, done_q, busy};
            ADDR_POP:     if (!fifo_empty) readdata = {1'b1, 19'h0, mem_q[rd_ptr_q]};
            ADDR_TOTAL:   readdata = {16'h0, total_q};
            ADDR_TIMEOUT: readdata = timeout_rd;
            default:      readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_move_mailbox_ctrl.sv
// Directed self-checking bench for move_mailbox_ctrl (default FIFO_DEPTH=16).
module tb_move_mailbox_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] address;
   logic        write, read;
   logic [31:0] writedata, readdata;
   logic        eng_start, eng_abort;
   logic        eng_move_valid;
   logic [11:0] eng_move;
   logic        eng_done;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int abort_cnt = 0;

   move_mailbox_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .address        (address),
      .write          (write),
      .read           (read),
      .writedata      (writedata),
      .readdata       (readdata),
      .eng_start      (eng_start),
      .eng_abort      (eng_abort),
      .eng_move_valid (eng_move_valid),
      .eng_move       (eng_move),
      .eng_done       (eng_done)
   );

   always #5 clk = ~clk;

   // Count engine strobes seen at each rising edge.
   always @(posedge clk) begin
      if (eng_start === 1'b1) start_cnt++;
      if (eng_abort === 1'b1) abort_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [13:0] a, input logic [31:0] d);
      address = a; writedata = d; write = 1'b1;
      tick();
      write = 1'b0; writedata = '0;
   endtask

   task automatic bus_read(input logic [13:0] a, output logic [31:0] d);
      address = a; read = 1'b1;
      #1;
      d = readdata;
      tick();
      read = 1'b0;
   endtask

   task automatic push_move(input logic [11:0] m);
      eng_move_valid = 1'b1; eng_move = m;
      tick();
      eng_move_valid = 1'b0; eng_move = '0;
   endtask

   task automatic pulse_done();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
   endtask

   logic [31:0] rd;
   int s0, a0;

   initial begin
      reset = 1'b1; address = '0; write = 1'b0; read = 1'b0; writedata = '0;
      eng_move_valid = 1'b0; eng_move = '0; eng_done = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Reset state
      check("idle_readdata", readdata, 32'h0);
      check("reset_start", {31'h0, eng_start}, 32'h0);
      check("reset_abort", {31'h0, eng_abort}, 32'h0);
      bus_read(14'h000, rd); check("reset_ctrl", rd, 32'h0);
`ifdef WATCHDOG_EN
      bus_read(14'h003, rd); check("reset_timeout", rd, 32'h00FFFFFF);
`else
      bus_read(14'h003, rd); check("reset_timeout", rd, 32'h0);
`endif
      bus_read(14'h3FFF, rd); check("unmapped_read", rd, 32'h0);

      // Write and read together: write wins, readdata is 0
      address = 14'h002; write = 1'b1; read = 1'b1; writedata = 32'h1234;
      #1 check("rw_collision", readdata, 32'h0);
      tick();
      write = 1'b0; read = 1'b0;

      // Basic run: two moves then eng_done
      bus_write(14'h000, 32'h1);
      check("start_pulse", {31'h0, eng_start}, 32'h1);
      push_move(12'h0C8);
      check("start_one_cycle", {31'h0, eng_start}, 32'h0);
      push_move(12'h1D1);
      pulse_done();
      tick();
      bus_read(14'h000, rd); check("run_ctrl", rd, 32'h00000202);
      bus_read(14'h001, rd); check("pop0", rd, 32'h800000C8);
      bus_read(14'h001, rd); check("pop1", rd, 32'h800001D1);
      bus_read(14'h001, rd); check("pop_empty", rd, 32'h0);
      bus_read(14'h002, rd); check("total2", rd, 32'h2);
      check("start_count1", start_cnt, 32'd1);

      // Overflow: 17 moves into a 16-deep FIFO
      bus_write(14'h000, 32'h1);
      for (int i = 0; i < 17; i++) push_move(12'h100 + 12'(i));
      pulse_done();
      tick();
      bus_read(14'h000, rd); check("ovf_ctrl", rd, 32'h00001006);
      bus_read(14'h002, rd); check("ovf_total", rd, 32'd17);
      for (int i = 0; i < 16; i++) begin
         bus_read(14'h001, rd);
         check($sformatf("ovf_pop%0d", i), rd, 32'h80000100 + 32'(i));
      end
      bus_read(14'h001, rd); check("ovf_17th_absent", rd, 32'h0);

      // START while busy ignored, ABORT pulses once, CLR clears overflow
      s0 = start_cnt;
      bus_write(14'h000, 32'h5);
      tick();
      bus_write(14'h000, 32'h1);
      tick(); tick();
      check("no_restart", start_cnt, s0 + 1);
      a0 = abort_cnt;
      address = 14'h000; writedata = 32'h2; write = 1'b1;
      #1 check("abort_comb", {31'h0, eng_abort}, 32'h1);
      tick();
      write = 1'b0; writedata = '0;
      check("abort_count", abort_cnt, a0 + 1);
      check("abort_one_cycle", {31'h0, eng_abort}, 32'h0);
      bus_read(14'h000, rd); check("abort_ctrl", rd, 32'h0);
      bus_write(14'h000, 32'h2);
      check("abort_idle_ignored", abort_cnt, a0 + 1);
      push_move(12'h0AA);
      bus_read(14'h000, rd); check("idle_push_dropped", rd, 32'h0);
      bus_read(14'h002, rd); check("idle_push_total", rd, 32'h0);

`ifdef WATCHDOG_EN
      // Watchdog: TIMEOUT=5, abort on 5th RUN cycle
      bus_write(14'h003, 32'h5);
      bus_read(14'h003, rd); check("timeout_rw", rd, 32'h5);
      a0 = abort_cnt;
      bus_write(14'h000, 32'h1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("wd_quiet%0d", k), {31'h0, eng_abort}, 32'h0);
      end
      tick();
      check("wd_abort", {31'h0, eng_abort}, 32'h1);
      tick();
      check("wd_abort_count", abort_cnt, a0 + 1);
      bus_read(14'h000, rd); check("wd_ctrl", rd, 32'h00000008);
      bus_write(14'h003, 32'h00FFFFFF);
`else
      // Without the watchdog, TIMEOUT is inert and RUN waits indefinitely
      bus_write(14'h003, 32'h5);
      bus_read(14'h003, rd); check("timeout_ro", rd, 32'h0);
      bus_write(14'h000, 32'h1);
      repeat (20) tick();
      bus_read(14'h000, rd); check("no_wd_busy", rd, 32'h00000001);
      bus_write(14'h000, 32'h2);
      bus_read(14'h000, rd); check("no_wd_abort_ctrl", rd, 32'h0);
`endif

      // Full FIFO with simultaneous push and pop, then CLR mid-run
      bus_write(14'h000, 32'h1);
      for (int i = 0; i < 16; i++) push_move(12'h200 + 12'(i));
      eng_move_valid = 1'b1; eng_move = 12'h2FF; address = 14'h001; read = 1'b1;
      #1 check("full_pushpop_data", readdata, 32'h80000200);
      tick();
      eng_move_valid = 1'b0; read = 1'b0;
      bus_read(14'h000, rd); check("full_pushpop_ctrl", rd, 32'h00001001);
      bus_write(14'h000, 32'h4);
      bus_read(14'h000, rd); check("clr_ctrl", rd, 32'h00000001);

      // Empty FIFO with simultaneous push and pop
      eng_move_valid = 1'b1; eng_move = 12'h3AB; address = 14'h001; read = 1'b1;
      #1 check("empty_pushpop_data", readdata, 32'h0);
      tick();
      eng_move_valid = 1'b0; read = 1'b0;
      bus_read(14'h000, rd); check("empty_pushpop_ctrl", rd, 32'h00000101);
      bus_read(14'h001, rd); check("empty_pushpop_pop", rd, 32'h800003AB);
      pulse_done();
      tick();
      bus_read(14'h000, rd); check("final_done", rd, 32'h00000002);

      // Reset mid-run: no abort pulse
      bus_write(14'h000, 32'h1);
      tick();
      a0 = abort_cnt;
      reset = 1'b1; address = 14'h000; writedata = 32'h2; write = 1'b1;
      #1 check("reset_no_abort", {31'h0, eng_abort}, 32'h0);
      tick();
      write = 1'b0; writedata = '0; reset = 1'b0;
      bus_read(14'h000, rd); check("reset_mid_ctrl", rd, 32'h0);
      check("reset_abort_count", abort_cnt, a0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
